// File: rtl/trap_pkg.sv
// ============================================================================
// Module   : trap_pkg
// Brief    : Shared types and constants for the trap sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_EPC    = 3'd1,
        ST_WR_CAUSE  = 3'd2,
        ST_WR_STATUS = 3'd3,
        ST_REDIRECT  = 3'd4,
        ST_MR_STATUS = 3'd5,
        ST_MR_REDIR  = 3'd6
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;

    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_if.sv
// ============================================================================
// Module   : trap_ctrl_if
// Brief    : Pipeline/CSR-file side bundle of the trap sequencer.
//            master = trap_ctrl, slave = pipeline and CSR file.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ext_irq;
    logic [XLEN-1:0] pc;
    logic            mret;
    logic [XLEN-1:0] mie;
    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            mtimecmp_wr;
    logic [XLEN-1:0] mtimecmp_data;
    logic            csr_wr_en;
    logic [11:0]     csr_wr_addr;
    logic [XLEN-1:0] csr_wr_data;
    logic            stall;
    logic            pc_redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] mtime;

    modport master (
        input  ext_irq, pc, mret, mie, mstatus, mtvec, mepc,
               mtimecmp_wr, mtimecmp_data,
        output csr_wr_en, csr_wr_addr, csr_wr_data, stall,
               pc_redirect, redirect_pc, mtime
    );

    modport slave (
        output ext_irq, pc, mret, mie, mstatus, mtvec, mepc,
               mtimecmp_wr, mtimecmp_data,
        input  csr_wr_en, csr_wr_addr, csr_wr_data, stall,
               pc_redirect, redirect_pc, mtime
    );
endinterface

`default_nettype wire

// File: rtl/trap_ctrl_mtimer.sv
// ============================================================================
// Module   : mtimer
// Brief    : Free-running mtime counter, mtimecmp register and compare.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mtimer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTIMECMP_RST = 32'hFFFF_FFFF
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_cmp_wr,
    input  wire logic [XLEN-1:0] i_cmp_data,
    output logic      [XLEN-1:0] o_mtime,
    output logic                 o_tmr_ge
);

    logic [XLEN-1:0] r_mtime;
    logic [XLEN-1:0] r_mtimecmp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RST;
        end else begin
            r_mtime <= r_mtime + 1'b1;
            if (i_cmp_wr) begin
                r_mtimecmp <= i_cmp_data;
            end
        end
    end

    assign o_mtime  = r_mtime;
    assign o_tmr_ge = (r_mtime >= r_mtimecmp);

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module   : trap_ctrl
// Brief    : Interrupt/trap sequencer feeding the CSR write port and fetch
//            redirect. Optional macro VECTORED_TRAP_EN enables vectored mtvec.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module trap_ctrl
    import trap_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTIMECMP_RST = 32'hFFFF_FFFF
) (
    input  wire logic    clk,
    input  wire logic    rst,
    trap_ctrl_if.master  bus
);

    state_t          r_state;
    logic            r_ext_s1;
    logic            r_ext_s2;
    logic [4:0]      r_cause_q;
    logic [XLEN-1:0] r_mstatus_q;
    logic            r_csr_wr_en;
    logic [11:0]     r_csr_wr_addr;
    logic [XLEN-1:0] r_csr_wr_data;
    logic            r_pc_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    logic [XLEN-1:0] w_mtime;
    logic            w_tmr_ge;
    logic            w_ext_pend;
    logic            w_tmr_pend;
    logic            w_take;
    logic [4:0]      w_cause;
    logic [XLEN-1:0] w_trap_status;
    logic [XLEN-1:0] w_mret_status;
    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_trap_target;
    logic            w_unused;

    mtimer #(
        .XLEN         (XLEN),
        .MTIMECMP_RST (MTIMECMP_RST)
    ) u_mtimer (
        .clk        (clk),
        .rst        (rst),
        .i_cmp_wr   (bus.mtimecmp_wr),
        .i_cmp_data (bus.mtimecmp_data),
        .o_mtime    (w_mtime),
        .o_tmr_ge   (w_tmr_ge)
    );

    assign w_ext_pend = r_ext_s2 & bus.mie[CAUSE_MEI];
    assign w_tmr_pend = w_tmr_ge & bus.mie[CAUSE_MTI];
    assign w_take     = bus.mstatus[MIE_BIT] & (w_ext_pend | w_tmr_pend);
    assign w_cause    = w_ext_pend ? CAUSE_MEI : CAUSE_MTI;

    always_comb begin
        w_trap_status                     = r_mstatus_q;
        w_trap_status[MPIE_BIT]           = r_mstatus_q[MIE_BIT];
        w_trap_status[MIE_BIT]            = 1'b0;
        w_trap_status[MPP_LO+1:MPP_LO]    = 2'b11;
    end

    always_comb begin
        w_mret_status           = bus.mstatus;
        w_mret_status[MIE_BIT]  = bus.mstatus[MPIE_BIT];
        w_mret_status[MPIE_BIT] = 1'b1;
    end

    assign w_trap_base = {bus.mtvec[XLEN-1:2], 2'b00};

`ifdef VECTORED_TRAP_EN
    assign w_trap_target = (bus.mtvec[1:0] == 2'b01)
                         ? w_trap_base + (XLEN'(r_cause_q) << 2)
                         : w_trap_base;
`else
    assign w_trap_target = w_trap_base;
`endif

    assign w_unused = ^{bus.mie, bus.mtvec[1:0]};

    // Outputs are registered on entry to each state, so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ext_s1      <= 1'b0;
            r_ext_s2      <= 1'b0;
            r_cause_q     <= '0;
            r_mstatus_q   <= '0;
            r_csr_wr_en   <= 1'b0;
            r_csr_wr_addr <= '0;
            r_csr_wr_data <= '0;
            r_pc_redirect <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_ext_s1      <= bus.ext_irq;
            r_ext_s2      <= r_ext_s1;
            r_csr_wr_en   <= 1'b0;
            r_csr_wr_addr <= '0;
            r_csr_wr_data <= '0;
            r_pc_redirect <= 1'b0;
            r_redirect_pc <= '0;
            case (r_state)
                ST_IDLE: begin
                    // A taken interrupt beats a coincident mret; the mret PC
                    // becomes mepc so it re-executes after the handler.
                    if (w_take) begin
                        r_cause_q     <= w_cause;
                        r_mstatus_q   <= bus.mstatus;
                        r_state       <= ST_WR_EPC;
                        r_csr_wr_en   <= 1'b1;
                        r_csr_wr_addr <= CSR_MEPC;
                        r_csr_wr_data <= bus.pc;
                    end else if (bus.mret) begin
                        r_state       <= ST_MR_STATUS;
                        r_csr_wr_en   <= 1'b1;
                        r_csr_wr_addr <= CSR_MSTATUS;
                        r_csr_wr_data <= w_mret_status;
                    end
                end
                ST_WR_EPC: begin
                    r_state       <= ST_WR_CAUSE;
                    r_csr_wr_en   <= 1'b1;
                    r_csr_wr_addr <= CSR_MCAUSE;
                    r_csr_wr_data <= {1'b1, (XLEN-1)'(r_cause_q)};
                end
                ST_WR_CAUSE: begin
                    r_state       <= ST_WR_STATUS;
                    r_csr_wr_en   <= 1'b1;
                    r_csr_wr_addr <= CSR_MSTATUS;
                    r_csr_wr_data <= w_trap_status;
                end
                ST_WR_STATUS: begin
                    r_state       <= ST_REDIRECT;
                    r_pc_redirect <= 1'b1;
                    r_redirect_pc <= w_trap_target;
                end
                ST_MR_STATUS: begin
                    r_state       <= ST_MR_REDIR;
                    r_pc_redirect <= 1'b1;
                    r_redirect_pc <= bus.mepc;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.stall       = (r_state != ST_IDLE);
    assign bus.mtime       = w_mtime;
    assign bus.csr_wr_en   = r_csr_wr_en;
    assign bus.csr_wr_addr = r_csr_wr_addr;
    assign bus.csr_wr_data = r_csr_wr_data;
    assign bus.pc_redirect = r_pc_redirect;
    assign bus.redirect_pc = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// Module   : tb_trap_ctrl
// Brief    : Scoreboard bench for trap_ctrl with a minimal CSR-file model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_trap_ctrl;
    import trap_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    trap_ctrl_if #(.XLEN(XLEN)) bus();

    trap_ctrl #(
        .XLEN         (XLEN),
        .MTIMECMP_RST (32'hFFFF_FFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            n_checks     = 0;
    int            n_errors     = 0;
    int            stall_cycles = 0;
    logic [95:0]   exp_q[$];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] ev_wr(input logic [11:0] a, input logic [31:0] d);
        return {18'h0, 1'b0, 1'b1, a, d, 32'h0};
    endfunction

    function automatic logic [95:0] ev_rd(input logic [31:0] t);
        return {18'h0, 1'b1, 1'b0, 12'h0, 32'h0, t};
    endfunction

    // Sample after the edge; act as the CSR file by applying observed writes.
    task automatic tick();
        logic [95:0] obs;
        @(posedge clk);
        #1;
        obs = {18'h0, bus.pc_redirect, bus.csr_wr_en, bus.csr_wr_addr,
               bus.csr_wr_data, bus.redirect_pc};
        if (bus.stall) stall_cycles++;
        if (bus.csr_wr_en || bus.pc_redirect) begin
            if (exp_q.size() == 0) check("unexpected_event", obs, 96'h0);
            else                   check("event", obs, exp_q.pop_front());
            if (bus.csr_wr_en) begin
                case (bus.csr_wr_addr)
                    CSR_MSTATUS: bus.mstatus = bus.csr_wr_data;
                    CSR_MEPC:    bus.mepc    = bus.csr_wr_data;
                    default: ;
                endcase
            end
        end else begin
            check("idle_outputs_zero", obs, 96'h0);
        end
    endtask

    task automatic drain(input string tag, input int exp_stall);
        int budget = 200;
        while ((exp_q.size() != 0 || bus.stall) && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_timeout"}, {95'h0, (budget == 0)}, 96'h0);
        check({tag, "_stall_cycles"}, 96'(stall_cycles), 96'(exp_stall));
        exp_q.delete();
    endtask

    task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] st, input logic [31:0] tgt);
        exp_q.push_back(ev_wr(CSR_MEPC, pc));
        exp_q.push_back(ev_wr(CSR_MCAUSE, cause));
        exp_q.push_back(ev_wr(CSR_MSTATUS, st));
        exp_q.push_back(ev_rd(tgt));
    endtask

    initial begin
        logic [31:0] vec_tgt;
        bus.ext_irq = 1'b0;       bus.pc = '0;          bus.mret = 1'b0;
        bus.mie = '0;             bus.mstatus = '0;     bus.mtvec = '0;
        bus.mepc = '0;            bus.mtimecmp_wr = 1'b0; bus.mtimecmp_data = '0;

        // Reset, count, then reset again mid-count
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("mtime_run", 96'(bus.mtime), 96'd3);
        rst = 1'b1;
        #1;
        check("rst_mtime", 96'(bus.mtime), 96'd0);
        check("rst_stall", 96'(bus.stall), 96'd0);
        check("rst_wr_en", 96'(bus.csr_wr_en), 96'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("mtime_after_5", 96'(bus.mtime), 96'd5);

        // Timer interrupt
        bus.mtimecmp_data = 32'd20;
        bus.mtimecmp_wr   = 1'b1;
        tick();
        bus.mtimecmp_wr   = 1'b0;
        bus.mtvec = 32'h100;
        bus.pc    = 32'h40;
        stall_cycles = 0;
        push_trap(32'h40, 32'h8000_0007, 32'h1880, 32'h100);
        bus.mie     = 32'h80;
        bus.mstatus = 32'h8;
        drain("timer", 4);
        check("timer_mstatus_model", 96'(bus.mstatus), 96'h1880);

        // External wins over a pending timer
        bus.mie     = 32'h880;
        bus.ext_irq = 1'b1;
        repeat (3) tick();
        stall_cycles = 0;
        push_trap(32'h40, 32'h8000_000B, 32'h1880, 32'h100);
        bus.mstatus = 32'h8;
        drain("ext", 4);
        bus.ext_irq = 1'b0;
        repeat (3) tick();

        // Two-flop synchroniser latency
        bus.mie     = 32'h800;
        bus.mstatus = 32'h8;
        stall_cycles = 0;
        push_trap(32'h40, 32'h8000_000B, 32'h1880, 32'h100);
        bus.ext_irq = 1'b1;
        tick();
        check("sync_cyc1_stall", 96'(bus.stall), 96'd0);
        tick();
        check("sync_cyc2_stall", 96'(bus.stall), 96'd0);
        tick();
        check("sync_cyc3_stall", 96'(bus.stall), 96'd1);
        drain("sync", 4);
        bus.ext_irq = 1'b0;
        repeat (3) tick();

        // Masked by mstatus.MIE
        bus.mstatus = 32'h0;
        bus.mie     = 32'h880;
        bus.ext_irq = 1'b1;
        stall_cycles = 0;
        repeat (50) tick();
        check("masked_stall", 96'(stall_cycles), 96'd0);
        bus.ext_irq = 1'b0;
        bus.mie     = 32'h0;
        repeat (3) tick();

        // mret
        bus.mstatus = 32'h80;
        bus.mepc    = 32'h44;
        exp_q.push_back(ev_wr(CSR_MSTATUS, 32'h88));
        exp_q.push_back(ev_rd(32'h44));
        stall_cycles = 0;
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        tick();
        check("mret_redirect_lat", 96'(bus.pc_redirect), 96'd1);
        drain("mret", 2);

        // mret coincident with a taken timer interrupt
        bus.pc    = 32'h60;
        bus.mtvec = 32'h100;
        push_trap(32'h60, 32'h8000_0007, 32'h1880, 32'h100);
        stall_cycles = 0;
        bus.mret = 1'b1;
        bus.mie  = 32'h80;
        tick();
        bus.mret = 1'b0;
        drain("simul", 4);

        // Vectored mtvec mode
        bus.mie = 32'h0;
        tick();
`ifdef VECTORED_TRAP_EN
        vec_tgt = 32'h11C;
`else
        vec_tgt = 32'h100;
`endif
        bus.mtvec = 32'h101;
        bus.pc    = 32'h80;
        push_trap(32'h80, 32'h8000_0007, 32'h1880, vec_tgt);
        stall_cycles = 0;
        bus.mstatus = 32'h8;
        bus.mie     = 32'h80;
        drain("vector", 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Interrupt/trap sequencer that sits directly upstream of the CSR file.
- Owns the machine timer: free-running mtime and a writable mtimecmp.
- Synchronises the external interrupt line and qualifies pending interrupts against mstatus.MIE and mie.
- On a taken interrupt or mret it drives a one-write-per-cycle CSR write port (mepc, mcause, mstatus), stalls the pipeline, then redirects the fetch PC.

Parameters:
XLEN, 32, data/PC width
MTIMECMP_RST, 32'hFFFF_FFFF, reset value of mtimecmp

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ext_irq  in  1  external interrupt request, asynchronous level
pc  in  XLEN  PC of instruction currently in execute
mret  in  1  mret decoded in execute, single-cycle pulse
mie  in  XLEN  current mie value from CSR file
mstatus  in  XLEN  current mstatus value from CSR file
mtvec  in  XLEN  current mtvec value from CSR file
mepc  in  XLEN  current mepc value from CSR file
mtimecmp_wr  in  1  load mtimecmp
mtimecmp_data  in  XLEN  new mtimecmp value
csr_wr_en  out  1  CSR write strobe
csr_wr_addr  out  12  CSR address being written
csr_wr_data  out  XLEN  CSR write data
stall  out  1  freeze fetch/decode/execute
pc_redirect  out  1  one-cycle fetch redirect strobe
redirect_pc  out  XLEN  redirect target
mtime  out  XLEN  timer value

Behaviour:
- Reset (async, immediate): state=IDLE; mtime=0; mtimecmp=MTIMECMP_RST; sync flops=0; latched regs=0; all outputs 0.
- mtime: +1 every cycle; wraps 32'hFFFF_FFFF -> 0.
- mtimecmp: loads on mtimecmp_wr in any state; visible to the compare next cycle.
- ext_irq passes through a 2-flop synchroniser, giving ext_s.
- Pending and take conditions:
  - ext_pend = ext_s & mie[11]
  - tmr_pend = (mtime >= mtimecmp, unsigned) & mie[7]
  - take = mstatus[3] & (ext_pend | tmr_pend)
- Priority: external (cause 11) over timer (cause 7).
- States and transitions:
  - IDLE: if take, latch pc->epc_q, cause_q, mstatus_q; go WR_EPC. Else if mret, go MR_STATUS. Else stay.
  - take and mret in the same cycle: interrupt wins; epc = PC of the mret, so it re-executes after return.
  - WR_EPC: csr_wr_en=1, addr=12'h341, data=epc_q -> WR_CAUSE.
  - WR_CAUSE: addr=12'h342, data={1'b1, 31'(cause_q)} -> WR_STATUS.
  - WR_STATUS: addr=12'h300, data=mstatus_q with MPIE[7]=MIE, MIE[3]=0, MPP[12:11]=2'b11 -> REDIRECT.
  - REDIRECT: pc_redirect=1, redirect_pc=trap target, csr_wr_en=0 -> IDLE.
  - MR_STATUS: addr=12'h300, data=mstatus with MIE[3]=MPIE[7], MPIE[7]=1 -> MR_REDIR.
  - MR_REDIR: pc_redirect=1, redirect_pc=mepc input -> IDLE.
- Trap target: {mtvec[31:2], 2'b00}.
- stall: 1 in every state except IDLE; combinational from state.
- Latency: take in IDLE cycle N gives mepc write at N+1 and pc_redirect at N+4. mret at N gives pc_redirect at N+2.
- csr_wr_addr and csr_wr_data are 0 whenever csr_wr_en=0.
- Interrupt deasserting mid-sequence: the sequence completes with the latched cause.
- No new interrupt is evaluated until back in IDLE. MIE is cleared by WR_STATUS, so no re-entry occurs.
- Reset mid-sequence: returns to IDLE immediately; partial CSR writes are not undone.

Optional Feature:
VECTORED_TRAP_EN
- Defined: when mtvec[1:0]==2'b01, trap target = {mtvec[31:2], 2'b00} + 4*cause_q.
- Undefined: mode bits are ignored and all traps go to {mtvec[31:2], 2'b00}.
- mret target is unaffected either way.

Decomposition:
Package trap_pkg holds:
- the state enum;
- CSR address constants: CSR_MSTATUS 12'h300, CSR_MIE 12'h304, CSR_MTVEC 12'h305, CSR_MEPC 12'h341, CSR_MCAUSE 12'h342, CSR_MIP 12'h344;
- mstatus bit indices: MIE_BIT=3, MPIE_BIT=7, MPP_LO=11;
- cause codes: CAUSE_MTI=7, CAUSE_MEI=11.

One sub-module, mtimer: mtime counter, mtimecmp register, compare output.

Test Plan:
1. Reset mid-count: rst high -> mtime=0, stall=0, csr_wr_en=0; rst low -> mtime=5 after 5 cycles.
2. Timer interrupt:
   - Stimulus: mtimecmp=20, mie=32'h80, mstatus=32'h8, mtvec=32'h100, pc=32'h40.
   - Response: writes 341<-0x40, 342<-0x80000007, 300<-0x1880; then pc_redirect with redirect_pc=0x100; stall high for 4 cycles.
3. External over timer:
   - Stimulus: both pending, mie=32'h880.
   - Response: mcause write 0x8000000B, no timer write; after 2-cycle sync delay, redirect to 0x100.
4. Masked: mstatus=0 with ext_irq high -> no csr_wr_en and no stall for 50 cycles.
5. mret:
   - Stimulus: mstatus=32'h80, mepc=32'h44, mret pulse.
   - Response: 300<-0x88; pc_redirect to 0x44 two cycles after the pulse.
6. Simultaneous and vectored cases:
   - mret coincident with a taken interrupt -> trap sequence runs, mepc write = pc of the mret.
   - With VECTORED_TRAP_EN and mtvec=0x101, a timer trap -> redirect_pc=0x11C.
